// File: rtl/ft_tx_arbiter_pkg.sv
// Shared types and defaults for the FTDI transmit arbiter.
// Holds the state encoding, the source encoding and the default widths.
package ft_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IQ_BURST,
      ST_CPU_BURST
   } state_t;

   localparam logic SRC_IQ  = 1'b0;
   localparam logic SRC_CPU = 1'b1;

   localparam int DEF_FT_DATA_WIDTH    = 32;
   localparam int DEF_IQ_PAIR_WIDTH    = 24;
   localparam int DEF_QSTART_BIT_INDEX = 16;
   localparam int DEF_BURST_LEN        = 16;

endpackage

// File: rtl/ft_tx_arbiter_iq_pack.sv
// Combinational packing of an I/Q pair into one FTDI word.
// I goes to the bottom of the word and Q starts at QSTART_BIT_INDEX; all other bits are zero.
module iq_pack
   import ft_tx_arbiter_pkg::*;
#(
   parameter int IQ_PAIR_WIDTH    = DEF_IQ_PAIR_WIDTH,
   parameter int FT_DATA_WIDTH    = DEF_FT_DATA_WIDTH,
   parameter int QSTART_BIT_INDEX = DEF_QSTART_BIT_INDEX
) (
   input  logic [IQ_PAIR_WIDTH-1:0] iq,
   output logic [FT_DATA_WIDTH-1:0] word
);

   localparam int HALF = IQ_PAIR_WIDTH / 2;

   always_comb begin
      word                           = '0;
      word[HALF-1:0]                 = iq[HALF-1:0];
      word[QSTART_BIT_INDEX +: HALF] = iq[IQ_PAIR_WIDTH-1 -: HALF];
   end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Round-robin burst arbiter between the IQ FIFO and the CPU FIFO onto the FTDI write path.
// A single output register is loaded while it is free or being drained, and the granted FIFO is popped in that same cycle.
module ft_tx_arbiter
   import ft_tx_arbiter_pkg::*;
#(
   parameter int FT_DATA_WIDTH    = DEF_FT_DATA_WIDTH,
   parameter int IQ_PAIR_WIDTH    = DEF_IQ_PAIR_WIDTH,
   parameter int QSTART_BIT_INDEX = DEF_QSTART_BIT_INDEX,
   parameter int BURST_LEN        = DEF_BURST_LEN
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic [IQ_PAIR_WIDTH-1:0] iq_data_i,
   input  logic                     iq_empty_i,
   output logic                     iq_re_o,
   input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
   input  logic                     cpu_empty_i,
   output logic                     cpu_re_o,
   output logic [FT_DATA_WIDTH-1:0] ft_data_o,
   output logic                     ft_valid_o,
   input  logic                     ft_ready_i,
   output logic                     ft_src_o,
   output logic                     busy_o
);

   localparam int              CW        = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0]   CNT_MAX   = CW'(BURST_LEN);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(BURST_LEN - 1);

   state_t                     state;
   logic [CW-1:0]              cnt;
   logic                       last_src;
   logic [FT_DATA_WIDTH-1:0]   iq_word;
   logic                       in_burst;
   logic                       gsrc;
   logic                       g_empty;
   logic                       room;
   logic                       load;

   iq_pack #(
      .IQ_PAIR_WIDTH    (IQ_PAIR_WIDTH),
      .FT_DATA_WIDTH    (FT_DATA_WIDTH),
      .QSTART_BIT_INDEX (QSTART_BIT_INDEX)
   ) u_iq_pack (
      .iq   (iq_data_i),
      .word (iq_word)
   );

   always_comb begin
      in_burst = (state != ST_IDLE);
      gsrc     = (state == ST_CPU_BURST) ? SRC_CPU : SRC_IQ;
      g_empty  = (gsrc == SRC_CPU) ? cpu_empty_i : iq_empty_i;
      room     = !ft_valid_o || ft_ready_i;
      load     = in_burst && !g_empty && (cnt < CNT_MAX) && room;
   end

   assign iq_re_o  = load && (gsrc == SRC_IQ);
   assign cpu_re_o = load && (gsrc == SRC_CPU);
   assign busy_o   = in_burst;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_src   <= SRC_CPU;
         ft_valid_o <= 1'b0;
         ft_data_o  <= '0;
         ft_src_o   <= SRC_IQ;
      end else begin
         if (load) begin
            ft_valid_o <= 1'b1;
            ft_data_o  <= (gsrc == SRC_CPU) ? cpu_data_i : iq_word;
            ft_src_o   <= gsrc;
            cnt        <= cnt + CW'(1);
         end else if (ft_valid_o && ft_ready_i) begin
            ft_valid_o <= 1'b0;
         end

         // Leaving on the final load keeps the inter-burst gap at exactly one IDLE cycle.
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (en_i && !iq_empty_i && (cpu_empty_i || last_src == SRC_CPU))
                  state <= ST_IQ_BURST;
               else if (en_i && !cpu_empty_i)
                  state <= ST_CPU_BURST;
            end
            default: begin
               if ((load && cnt == CNT_LAST) || (room && g_empty) || (cnt >= CNT_MAX)) begin
                  state    <= ST_IDLE;
                  last_src <= gsrc;
               end
            end
         endcase
      end
   end

endmodule
